// File: rtl/uart_rx_if.sv
// Output word channel of the oversampling UART receiver: the held word, its status flags
// and the valid/ready handshake.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;

  modport master (
    output data_out, data_valid, parity_err, frame_err, overrun_err,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, parity_err, frame_err, overrun_err,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote bit decisions, configurable framing and a
// valid/ready output register that carries parity, framing and overrun status per word.
module uart_rx_os #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx_en,
  input  logic      rx,
  output logic      busy,
  uart_rx_if.master bus
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PH_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]  PH_A      = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0]  PH_B      = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0]  PH_C      = PH_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]       IDX_LAST  = 4'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t state, state_nxt;

  logic                 rx_p0, rx_s, rx_s_d;
  logic [DIV_W-1:0]     div_cnt;
  logic [PH_W-1:0]      ph;
  logic [3:0]           idx;
  logic                 stop_idx;
  logic                 smp_a, smp_b;
  logic [DATA_BITS-1:0] sr;
  logic                 perr, ferr;

  logic tick, decide, bit_val, start_det, done, accept, load;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign tick      = (div_cnt == DIV_LAST);
  assign decide    = tick && (ph == PH_C) && (state != S_IDLE);
  assign bit_val   = maj3(smp_a, smp_b, rx_s);
  assign start_det = (state == S_IDLE) && rx_en && rx_s_d && !rx_s;
  assign done      = (state == S_STOP) && decide && (stop_idx == STOP_LAST);
  assign accept    = bus.data_valid && bus.data_ready;
  assign load      = done && (!bus.data_valid || accept);
  assign busy      = (state != S_IDLE);

  // Input synchroniser; rx_s_d gives the falling-edge reference for start detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0  <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_p0  <= rx;
      rx_s   <= rx_p0;
      rx_s_d <= rx_s;
    end
  end

  // Tick divider, re-phased at every start edge so bit sampling aligns to the frame
  always_ff @(posedge clk) begin
    if (rst || start_det || tick) div_cnt <= '0;
    else                          div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_det) state_nxt = S_START;
      S_START: if (decide) state_nxt = bit_val ? S_IDLE : S_DATA;
      S_DATA:  if (decide && (idx == IDX_LAST)) state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (decide) state_nxt = S_STOP;
      S_STOP:  if (done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit-level counters and frame flags
  always_ff @(posedge clk) begin
    if (rst) begin
      ph       <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else if (state == S_IDLE) begin
      ph       <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      if (start_det) begin
        perr <= 1'b0;
        ferr <= 1'b0;
      end
    end else if (tick) begin
      ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
      if (decide) begin
        case (state)
          S_DATA:  idx <= idx + 4'd1;
          S_PAR:   perr <= ((^sr) ^ bit_val) != ODD;
          S_STOP: begin
            ferr     <= ferr | ~bit_val;
            stop_idx <= stop_idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Sample and shift datapath; LSB arrives first, so shifting right lands bit 0 at sr[0]
  always_ff @(posedge clk) begin
    if (tick && (ph == PH_A)) smp_a <= rx_s;
    if (tick && (ph == PH_B)) smp_b <= rx_s;
    if ((state == S_DATA) && decide) sr <= {bit_val, sr[DATA_BITS-1:1]};
  end

  // Output register: a completion arriving while a word is still held only marks overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_out    <= '0;
      bus.data_valid  <= 1'b0;
      bus.parity_err  <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.overrun_err <= 1'b0;
    end else if (load) begin
      bus.data_out    <= sr;
      bus.data_valid  <= 1'b1;
      bus.parity_err  <= perr;
      bus.frame_err   <= ferr | ~bit_val;
      bus.overrun_err <= 1'b0;
    end else if (done) begin
      bus.overrun_err <= 1'b1;
    end else if (accept) begin
      bus.data_valid  <= 1'b0;
      bus.parity_err  <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.overrun_err <= 1'b0;
    end
  end

endmodule
